// File: rtl/cmpeq_pkg.sv
// Shared types and constants for the chunk-serial equality comparator.
// Holds the FSM state encoding and the compare mode values.
package cmpeq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_EQ = 1'b0;
  localparam logic MODE_NE = 1'b1;

endpackage

// File: rtl/cmpeq_chunk.sv
// Combinational equality check for one CHUNK-bit slice.
// Output is high when both inputs match bit for bit.
module cmpeq_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             eq
);

  logic [CHUNK-1:0] diff;

  assign diff = x ^ y;
  assign eq   = ~(|diff);

endmodule

// File: rtl/cmpeq_seq.sv
// Sequential comparator: walks the operands CHUNK bits per cycle, LSB chunk
// first, and exits early on the first mismatching chunk.
module cmpeq_seq
  import cmpeq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CHUNK = 2,
  localparam int NCH   = WIDTH / CHUNK,
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             o,
  output logic [IW-1:0]    mism_idx,
  output logic [1:0]       dbg_state
);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("cmpeq_seq: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_t             state;
  logic [IW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               mode_q;
  logic [CHUNK-1:0]   a_ch [NCH];
  logic [CHUNK-1:0]   b_ch [NCH];
  logic [CHUNK-1:0]   a_sel;
  logic [CHUNK-1:0]   b_sel;
  logic               chunk_eq;
  logic               accept;

  // Slice the latched operands so the only width-dependent logic is this mux.
  for (genvar g = 0; g < NCH; g++) begin : g_slice
    assign a_ch[g] = a_q[g*CHUNK +: CHUNK];
    assign b_ch[g] = b_q[g*CHUNK +: CHUNK];
  end

  assign a_sel = a_ch[cnt];
  assign b_sel = b_ch[cnt];

  cmpeq_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (a_sel),
    .y  (b_sel),
    .eq (chunk_eq)
  );

  assign accept    = start && (state != RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_EQ;
      o        <= 1'b0;
      mism_idx <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!chunk_eq) begin
            state    <= DONE;
            o        <= 1'b0 ^ mode_q;
            mism_idx <= cnt;
          end else if (cnt == LAST) begin
            state    <= DONE;
            o        <= 1'b1 ^ mode_q;
            mism_idx <= '0;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
          if (accept) begin
            state  <= RUN;
            cnt    <= '0;
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmpeq_seq.sv
// Directed bench for cmpeq_seq (WIDTH=8, CHUNK=2) plus a CHUNK=WIDTH instance.
module tb_cmpeq_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       mode;
  logic       busy;
  logic       done;
  logic       o;
  logic [1:0] mism_idx;
  logic [1:0] dbg_state;
  logic       busy1;
  logic       done1;
  logic       o1;
  logic [0:0] mism_idx1;
  logic [1:0] dbg_state1;

  int checks;
  int errors;

  cmpeq_seq #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .o         (o),
    .mism_idx  (mism_idx),
    .dbg_state (dbg_state)
  );

  cmpeq_seq #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .busy      (busy1),
    .done      (done1),
    .o         (o1),
    .mism_idx  (mism_idx1),
    .dbg_state (dbg_state1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: present a request, let it be accepted, then count edges to done.
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input logic mv,
                         output int lat, output int busy_cnt);
    a = av; b = bv; mode = mv; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h12; mode = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (o !== 1'b0 || mism_idx !== 2'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: o=%b idx=%0d st=%0d want 0 0 0", o, mism_idx, dbg_state);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_equal();
    int lat, bc;
    run_cmp(8'hA5, 8'hA5, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL equal_latency: got %0d want 4", lat);
    end
    checks++;
    if (o !== 1'b1 || mism_idx !== 2'd0) begin
      errors++;
      $display("FAIL equal_result: o=%b idx=%0d want 1 0", o, mism_idx);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL equal_busy_cycles: got %0d want 4", bc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL equal_busy_at_done: got %b want 0", busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || o !== 1'b1) begin
      errors++;
      $display("FAIL equal_pulse_hold: done=%b o=%b want 0 1", done, o);
    end
  endtask

  task automatic test_early_mismatch();
    int lat, bc;
    run_cmp(8'hA5, 8'hA4, 1'b0, lat, bc);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL early_latency: got %0d want 1", lat);
    end
    checks++;
    if (o !== 1'b0 || mism_idx !== 2'd0) begin
      errors++;
      $display("FAIL early_result: o=%b idx=%0d want 0 0", o, mism_idx);
    end
    step();
  endtask

  task automatic test_ne_mode();
    int lat, bc;
    run_cmp(8'h35, 8'hB5, 1'b1, lat, bc);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL ne_latency: got %0d want 4", lat);
    end
    checks++;
    if (o !== 1'b1 || mism_idx !== 2'd3) begin
      errors++;
      $display("FAIL ne_result: o=%b idx=%0d want 1 3", o, mism_idx);
    end
    step();
    step();
    checks++;
    if (o !== 1'b1 || mism_idx !== 2'd3) begin
      errors++;
      $display("FAIL ne_hold_idle: o=%b idx=%0d want 1 3", o, mism_idx);
    end
  endtask

  task automatic test_ignore_start();
    int dones, done_at;
    logic o_at;
    a = 8'h00; b = 8'h00; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0; done_at = -1; o_at = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        start = 1'b1; a = 8'hFF;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        dones++;
        if (done_at < 0) begin
          done_at = k;
          o_at = o;
        end
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d want 1", dones);
    end
    checks++;
    if (done_at !== 4 || o_at !== 1'b1) begin
      errors++;
      $display("FAIL ignore_result: done_at=%0d o=%b want 4 1", done_at, o_at);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 8'hA5; b = 8'hA5; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    start = 1'b1; a = 8'h0F; b = 8'h1F;
    step();
    checks++;
    if (done !== 1'b1 || o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b o=%b want 1 1", done, o);
    end
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b want 1 0", busy, done);
    end
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d want 3", lat);
    end
    checks++;
    if (o !== 1'b0 || mism_idx !== 2'd2) begin
      errors++;
      $display("FAIL b2b_second_result: o=%b idx=%0d want 0 2", o, mism_idx);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int dones;
    run_cmp(8'h35, 8'hB5, 1'b1, dones, dones);
    step();
    a = 8'hA5; b = 8'hA5; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy_done: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (o !== 1'b0 || mism_idx !== 2'd0) begin
      errors++;
      $display("FAIL abort_outputs: o=%b idx=%0d want 0 0", o, mism_idx);
    end
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_quiet: active cycles=%0d want 0", dones);
    end
  endtask

  task automatic test_single_chunk();
    a = 8'h35; b = 8'hB5; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL nch1_busy: got %b want 1", busy1);
    end
    step();
    checks++;
    if (done1 !== 1'b1 || o1 !== 1'b0 || mism_idx1 !== 1'b0) begin
      errors++;
      $display("FAIL nch1_mismatch: done=%b o=%b idx=%0d want 1 0 0", done1, o1, mism_idx1);
    end
    a = 8'h5A; b = 8'h5A; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (done1 !== 1'b1 || o1 !== 1'b0) begin
      errors++;
      $display("FAIL nch1_equal_ne: done=%b o=%b want 1 0", done1, o1);
    end
    a = 8'h5A; b = 8'h5B; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (done1 !== 1'b1 || o1 !== 1'b1) begin
      errors++;
      $display("FAIL nch1_diff_ne: done=%b o=%b want 1 1", done1, o1);
    end
    for (int k = 0; k < 6; k++) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; mode = 1'b0;
    test_reset();
    test_equal();
    test_early_mismatch();
    test_ne_mode();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmpeq_seq.md
CMPEQ_SEQ -- requirements
Module: cmpeq_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (>= 1).
REQ-002 Parameter CHUNK, default 2, bits compared per cycle (1 <= CHUNK <= WIDTH); WIDTH % CHUNK SHALL be 0, else elaboration error.
REQ-003 Derived NCH = WIDTH/CHUNK (chunk count); IW = max(1, clog2(NCH)).
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  request a compare; accepted only when not busy.
REQ-007 a  input  WIDTH  operand A, sampled on the accepting edge only.
REQ-008 b  input  WIDTH  operand B, sampled on the accepting edge only.
REQ-009 mode  input  1  0 = equality (o=1 when a==b), 1 = inequality (o=1 when a!=b); sampled on the accepting edge.
REQ-010 busy  output  1  high while a compare is in progress.
REQ-011 done  output  1  single-cycle pulse marking a valid result.
REQ-012 o  output  1  compare result; valid from done and held until the next done.
REQ-013 mism_idx  output  IW  index of the first mismatching chunk (LSB chunk = 0); 0 when operands are equal.

Function
REQ-014 FSM states: IDLE, RUN, DONE; encoding from the package.
REQ-015 IDLE or DONE with start=1: latch a, b, mode; clear chunk counter cnt to 0; go to RUN; busy=1 from the next cycle.
REQ-016 RUN, each edge: compare latched chunk cnt (bits cnt*CHUNK+CHUNK-1 .. cnt*CHUNK), LSB chunk first.
REQ-017 RUN, chunk mismatch: early exit; go to DONE; eq=0; mism_idx=cnt.
REQ-018 RUN, chunk match with cnt < NCH-1: increment cnt; stay in RUN.
REQ-019 RUN, chunk match with cnt == NCH-1: go to DONE; eq=1; mism_idx=0.
REQ-020 o SHALL be eq XOR latched mode, registered on the same edge that enters DONE.
REQ-021 DONE lasts exactly one cycle: done=1, busy=0; without start, return to IDLE.
REQ-022 Latency: done asserts exactly i+1 cycles after the accepting edge, where i is the deciding chunk index; full match takes NCH cycles.
REQ-023 start while busy (RUN) SHALL be ignored; a, b and mode changes during RUN SHALL have no effect.
REQ-024 start during DONE SHALL be accepted as a back-to-back compare; done still pulses for the finishing compare.
REQ-025 o and mism_idx SHALL hold their values in IDLE and RUN until the next DONE.
REQ-026 CHUNK == WIDTH (NCH = 1): every compare completes in 1 cycle; mism_idx is constant 0.

Reset
REQ-027 rst_n=0 at an edge: state=IDLE, cnt=0, busy=0, done=0, o=0, mism_idx=0, latched operands cleared.
REQ-028 Reset during RUN SHALL abort the compare with no done pulse; start asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-029 Package cmpeq_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the MODE_EQ=0 / MODE_NE=1 constants.
REQ-030 One sub-module, cmpeq_chunk (param CHUNK, purely combinational): output is 1 when its two inputs are equal, built as per-bit xor, or-reduce, invert; instantiated once on the muxed chunk.
REQ-031 The chunk mux and cnt SHALL be the only width-dependent datapath; no full-WIDTH comparator.

Verification (WIDTH=8, CHUNK=2, NCH=4)
REQ-032 a=8'hA5, b=8'hA5, mode=0 -> done 4 cycles after accept; o=1, mism_idx=0; busy high for 4 cycles.
REQ-033 a=8'hA5, b=8'hA4, mode=0 -> done 1 cycle after accept; o=0, mism_idx=0.
REQ-034 a=8'h35, b=8'hB5, mode=1 -> done 4 cycles after accept; o=1, mism_idx=3.
REQ-035 Accept a=b=8'h00; in RUN pulse start with a=8'hFF -> ignored; o=1 at done; exactly one done pulse.
REQ-036 Start held high through DONE with a new pair a=8'h0F, b=8'h1F -> second compare starts immediately; second done gives o=0, mism_idx=2.
REQ-037 rst_n=0 in the second RUN cycle -> busy=0, done=0, o=0, mism_idx=0 next cycle; no done until a new start.
